// File: rtl/secure_router_pkg.sv
// Shared definitions for the secure router and its port receivers.
// Code word layout and the even-parity helper live here.
package secure_router_pkg;

    localparam int PAYLOAD_W = 6;
    localparam int CODE_W    = 7;

    typedef struct packed {
        logic                 par;
        logic [PAYLOAD_W-1:0] payload;
    } code_t;

    function automatic logic even_parity(input logic [PAYLOAD_W-1:0] p);
        return ^p;
    endfunction

endpackage

// File: rtl/secure_rx_fifo.sv
// Payload FIFO for one router output port: storage, pointers, occupancy.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module secure_rx_fifo
    import secure_router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [PAYLOAD_W-1:0] wr_data,
    output logic                 push_acc,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pop       = !empty && out_ready;
    assign push_acc  = push && (!full || pop);
    assign out_valid = !empty;
    // Gate the head so the output reads 0 while empty or in reset.
    assign out_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_acc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/secure_port_receiver.sv
// Receiver for one router port: parity check, buffering, sticky overflow.
// Define SECURE_RX_ERR_CNT_EN to build the saturating parity-error counter.
module secure_port_receiver
    import secure_router_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CODE_W-1:0]    d_in,
    input  logic                 in_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic [CNT_W-1:0]     err_count
);

    code_t word;
    logic  good;
    logic  push;
    logic  push_acc;

    assign word = code_t'(d_in);
    assign good = (word.par == even_parity(word.payload));
    assign push = in_valid && good;

    secure_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wr_data  (word.payload),
        .push_acc (push_acc),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && !push_acc) begin
            overflow <= 1'b1;
        end
    end

`ifdef SECURE_RX_ERR_CNT_EN
    logic [CNT_W-1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (in_valid && !good && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_secure_port_receiver.sv
// Directed bench for secure_port_receiver (DEPTH=4, CNT_W=8).
// Counter expectations follow the SECURE_RX_ERR_CNT_EN build setting.
module tb_secure_port_receiver;

`ifdef SECURE_RX_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [6:0] d_in;
    logic       in_valid;
    logic [5:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic [7:0] err_count;

    int checks;
    int errors;

    secure_port_receiver #(
        .DEPTH(4),
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_in     (d_in),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow (overflow),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] good_w(input logic [5:0] p);
        return {^p, p};
    endfunction

    function automatic logic [6:0] bad_w(input logic [5:0] p);
        return {~(^p), p};
    endfunction

    logic [5:0] exp_q [4];
    logic [7:0] exp_err;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        d_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        #10 rst_n = 1'b1;
        step();

        // single good word, consumer always ready
        d_in      = 7'b1001110;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h0e);
        step();
        chk("single_gone", 32'(out_valid), 32'd0);

        // in_valid low: nothing sampled
        d_in = good_w(6'h15);
        step();
        chk("no_valid_no_push", 32'(out_valid), 32'd0);

        // bad parity word
        d_in     = 7'b0001110;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bad_not_queued", 32'(out_valid), 32'd0);
        exp_err = CNT_ON ? 8'd1 : 8'd0;
        chk("err_one", 32'(err_count), 32'(exp_err));

        in_valid = 1'b1;
        for (int i = 0; i < 99; i++) begin
            d_in = bad_w(6'(i));
            step();
        end
        exp_err = CNT_ON ? 8'd100 : 8'd0;
        chk("err_hundred", 32'(err_count), 32'(exp_err));
        for (int i = 0; i < 201; i++) begin
            d_in = bad_w(6'(i + 7));
            step();
        end
        in_valid = 1'b0;
        exp_err = CNT_ON ? 8'd255 : 8'd0;
        chk("err_saturate", 32'(err_count), 32'(exp_err));
        chk("bad_burst_empty", 32'(out_valid), 32'd0);

        // overflow: five words into a four-entry FIFO
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d_in = good_w(6'(i));
            step();
        end
        chk("fill_no_ovf", 32'(overflow), 32'd0);
        chk("fill_head", 32'(out_data), 32'h01);
        d_in = good_w(6'h05);
        step();
        in_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head_stable", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_valid", 32'(out_valid), 32'd1);
            chk("ovf_pop_data", 32'(out_data), 32'(i));
            step();
        end
        chk("ovf_drained", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // mid-stream asynchronous reset with three words buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_in = good_w(6'(8'h30 + i));
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        // full FIFO: push and pop in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_in = good_w(6'(8'h11 + i));
            step();
        end
        d_in      = good_w(6'h2a);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fullpp_valid", 32'(out_valid), 32'd1);
        chk("fullpp_no_ovf", 32'(overflow), 32'd0);
        exp_q[0] = 6'h12;
        exp_q[1] = 6'h13;
        exp_q[2] = 6'h14;
        exp_q[3] = 6'h2a;
        for (int i = 0; i < 4; i++) begin
            chk("fullpp_data", 32'(out_data), 32'(exp_q[i]));
            step();
        end
        chk("fullpp_drained", 32'(out_valid), 32'd0);

        // push while empty with out_ready high: no bypass
        in_valid = 1'b1;
        d_in     = good_w(6'h3f);
        #1;
        chk("no_bypass", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("push_empty_valid", 32'(out_valid), 32'd1);
        chk("push_empty_data", 32'(out_data), 32'h3f);
        step();
        chk("push_empty_gone", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
